// File: rtl/mem_arbiter.sv
// mem_arbiter - round-robin req/ack arbiter sharing one memory port between fetch and data sides.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic              iAck,
    output logic [DATA_W-1:0] iRdata,
    output logic              iErr,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic              dAck,
    output logic [DATA_W-1:0] dRdata,
    output logic              dErr,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    input  logic              memReady
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              last_d;      // side of the most recent grant, also the side being served
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic [DATA_W-1:0] d_rdata;
    logic              i_err;
    logic              d_err;
    logic              start_i;
    logic              start_d;
    logic              done_ok;
    logic              done_to;
    logic              busy;

    assign busy = (state == I_BUSY) || (state == D_BUSY);

    always_comb begin
        state_nx = state;
        start_i  = 1'b0;
        start_d  = 1'b0;
        done_ok  = 1'b0;
        done_to  = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the side opposite the previous grant wins
                if (iReq && (!dReq || last_d)) begin
                    start_i  = 1'b1;
                    state_nx = I_BUSY;
                end else if (dReq) begin
                    start_d  = 1'b1;
                    state_nx = D_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (memReady) begin
                    done_ok  = 1'b1;
                    state_nx = RESP;
                end else if (wait_cnt == TO_LAST) begin
                    done_to  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_i) begin
                lat_addr  <= iAddr;
                lat_we    <= 1'b0;
                lat_wdata <= '0;
                last_d    <= 1'b0;
                wait_cnt  <= '0;
            end
            if (start_d) begin
                lat_addr  <= dAddr;
                lat_we    <= dWe;
                lat_wdata <= dWdata;
                last_d    <= 1'b1;
                wait_cnt  <= '0;
            end
            if (done_ok || done_to) begin
                if (last_d) begin
                    d_rdata <= done_ok ? memRdata : '0;
                    d_err   <= done_to;
                end else begin
                    i_rdata <= done_ok ? memRdata : '0;
                    i_err   <= done_to;
                end
            end else if (busy && (wait_cnt != TO_LAST)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign memEn    = busy;
    assign memWe    = busy && lat_we;
    assign memAddr  = lat_addr;
    assign memWdata = lat_wdata;
    assign iAck     = (state == RESP) && !last_d;
    assign dAck     = (state == RESP) && last_d;
    assign iRdata   = i_rdata;
    assign iErr     = i_err;
    assign dRdata   = d_rdata;
    assign dErr     = d_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter - randomized scoreboard bench for mem_arbiter.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;
    localparam int N  = 40;

    logic          CLK = 1'b0;
    logic          RES;
    logic          iReq, iAck, iErr, dReq, dWe, dAck, dErr;
    logic          memEn, memWe, memReady;
    logic [AW-1:0] iAddr, dAddr, memAddr;
    logic [DW-1:0] iRdata, dRdata, dWdata, memWdata, memRdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RES(RES),
        .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRdata(iRdata), .iErr(iErr),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dAck(dAck), .dRdata(dRdata), .dErr(dErr),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memReady(memReady)
    );

    always #5 CLK = ~CLK;

    // One request in flight per side; address bit 31 tells the sides apart on the memory bus
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          w;
    } txn_t;

    txn_t qi[$];
    txn_t qd[$];
    int   errors = 0;
    int   checks = 0;
    bit   go = 1'b0, done_i = 1'b0, done_d = 1'b0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_txn(input bit side, input int w);
        txn_t        t;
        logic [31:0] r;
        bit          got;
        r       = $urandom;
        t.addr  = {side, r[30:2], 2'b00};
        t.we    = side ? 1'($urandom_range(0, 1)) : 1'b0;
        t.wdata = side ? 32'($urandom) : 32'h0;
        t.w     = w;
        if (side) begin
            qd.push_back(t);
            dAddr = t.addr; dWe = t.we; dWdata = t.wdata; dReq = 1'b1;
        end else begin
            qi.push_back(t);
            iAddr = t.addr; iReq = 1'b1;
        end
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge CLK);
            got = side ? dAck : iAck;
        end
        if (side) dReq = 1'b0; else iReq = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_wait side=%0d: got no ack expected ack within 300 cycles", side);
        end
    endtask

    function automatic int pick_w(input bit side, input int n);
        int r;
        if (side && n == 1) return TO - 1;   // ready on the last permitted cycle
        if (side && n == 2) return TO + 2;   // never ready: timeout
        if (side && n == 3) return 3;
        r = $urandom_range(0, 9);
        if (r < 7)  return $urandom_range(0, 4);
        if (r == 7) return TO - 1;
        if (r == 8) return TO;
        return TO + 3;
    endfunction

    task automatic requester(input bit side);
        wait (go);
        for (int n = 0; n < N; n++) begin
            if (n > 0) repeat ($urandom_range(0, 2)) @(negedge CLK);
            run_txn(side, pick_w(side, n));
        end
    endtask

    initial begin requester(1'b0); done_i = 1'b1; end
    initial begin requester(1'b1); done_d = 1'b1; end

    // Memory model: ready arrives on busy cycle index w, data is a fixed function of address
    int mk, mw;
    bit mprev = 1'b0;
    initial begin
        memReady = 1'b0;
        memRdata = '0;
        forever begin
            @(negedge CLK);
            if (memEn) begin
                mk = mprev ? mk + 1 : 0;
                mw = 0;
                if (memAddr[31]) begin
                    if (qd.size() > 0) mw = qd[0].w;
                end else if (qi.size() > 0) begin
                    mw = qi[0].w;
                end
                memReady = (mk == mw);
                memRdata = memReady ? mem_fn(memAddr) : 32'($urandom);
            end else begin
                memReady = 1'($urandom_range(0, 1));
                memRdata = 32'($urandom);
            end
            mprev = memEn;
        end
    end

    // Monitor/scoreboard, sampling just after each rising edge
    bit   prev_en = 1'b0, last_d = 1'b1, cur_d = 1'b0, fell, side, exp_side;
    int   busy = 0, exp_busy;
    txn_t h;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (RES) begin
                chk("reset_flags", {58'd0, iAck, dAck, iErr, dErr, memEn, memWe}, 64'd0);
                chk("reset_iRdata", iRdata, 0);
                chk("reset_dRdata", dRdata, 0);
                chk("reset_memAddr", memAddr, 0);
                chk("reset_memWdata", memWdata, 0);
                prev_en = 1'b0;
                busy    = 0;
                last_d  = 1'b1;
            end else begin
                fell = prev_en && !memEn;
                if (iAck || dAck || fell) begin
                    chk("iAck_timing", iAck, fell && !cur_d);
                    chk("dAck_timing", dAck, fell && cur_d);
                end
                if (memWe) chk("memWe_needs_memEn", memEn, 1);
                if (memEn && !prev_en) begin
                    side     = memAddr[31];
                    exp_side = (iReq && dReq) ? !last_d : dReq;
                    chk("grant_side", side, exp_side);
                    last_d = side;
                    cur_d  = side;
                    busy   = 1;
                    if ((side ? qd.size() : qi.size()) == 0) begin
                        chk("grant_with_request", 0, 1);
                    end else begin
                        h = side ? qd[0] : qi[0];
                        chk("memAddr", memAddr, h.addr);
                        chk("memWe", memWe, h.we);
                        chk("memWdata", memWdata, h.wdata);
                    end
                end else if (memEn) begin
                    busy++;
                end
                if (fell) begin
                    if ((cur_d ? qd.size() : qi.size()) == 0) begin
                        chk("response_with_request", 0, 1);
                    end else begin
                        h = cur_d ? qd.pop_front() : qi.pop_front();
                        exp_busy = (h.w < TO) ? h.w + 1 : TO;
                        chk("busy_cycles", busy, exp_busy);
                        if (cur_d) begin
                            chk("dRdata", dRdata, (h.w < TO) ? mem_fn(h.addr) : 32'h0);
                            chk("dErr", dErr, h.w >= TO);
                        end else begin
                            chk("iRdata", iRdata, (h.w < TO) ? mem_fn(h.addr) : 32'h0);
                            chk("iErr", iErr, h.w >= TO);
                        end
                    end
                end
                prev_en = memEn;
            end
        end
    end

    initial begin
        RES = 1'b1; iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        iAddr = '0; dAddr = '0; dWdata = '0;
        repeat (2) @(negedge CLK);
        RES = 1'b0;
        go  = 1'b1;
        for (int c = 0; c < 20000 && !(done_i && done_d); c++) @(negedge CLK);
        if (!(done_i && done_d)) begin
            checks++;
            errors++;
            $display("FAIL random_phase: got unfinished expected both requesters done");
        end
        repeat (2) @(negedge CLK);

        // Reset in the middle of a data access: aborted silently, then re-issued
        qd.push_back('{addr: 32'h8000_3000, we: 1'b0, wdata: 32'h0, w: 100});
        dAddr = 32'h8000_3000; dWe = 1'b0; dWdata = '0; dReq = 1'b1;
        repeat (4) @(negedge CLK);
        chk("busy_before_reset", memEn, 1);
        RES = 1'b1;
        @(negedge CLK);
        RES  = 1'b0;
        dReq = 1'b0;
        void'(qd.pop_front());
        @(negedge CLK);
        chk("no_dAck_after_reset", dAck, 0);
        chk("no_memEn_after_reset", memEn, 0);
        run_txn(1'b1, 2);
        repeat (3) @(negedge CLK);
        chk("qi_drained", qi.size(), 0);
        chk("qd_drained", qd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the multicycle RISC-V core. It shares one memory port between the instruction-fetch requester (FETCH state) and the data requester (load/store MEM_ACCESS state) using a registered req/ack handshake. Ties are resolved round-robin, and a wait-state timeout reports a bus error instead of hanging the core. It sits between the control unit/datapath and the unified instruction/data memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max cycles in a busy state without memReady before error (≥1)

- CLK  in  1  clock, all state updates on rising edge
- RES  in  1  reset; one clock; reset is synchronous and active-high
- iReq  in  1  fetch request, held until iAck
- iAddr  in  ADDR_W  fetch address, stable while iReq
- iAck  out  1  one-cycle fetch completion pulse
- iRdata  out  DATA_W  fetch data, valid when iAck
- iErr  out  1  fetch timed out, valid when iAck
- dReq  in  1  data request, held until dAck
- dWe  in  1  1 = store, 0 = load; stable while dReq
- dAddr  in  ADDR_W  data address
- dWdata  in  DATA_W  store data
- dAck  out  1  one-cycle data completion pulse
- dRdata  out  DATA_W  load data, valid when dAck
- dErr  out  1  data access timed out, valid when dAck
- memEn  out  1  memory access active
- memWe  out  1  memory write strobe
- memAddr  out  ADDR_W  memory address
- memWdata  out  DATA_W  memory write data
- memRdata  in  DATA_W  memory read data, sampled with memReady
- memReady  in  1  memory completes the access this cycle

## Operation
- States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE: memEn=0. Grant selection:
  - only iReq set → I_BUSY; only dReq set → D_BUSY.
  - both set → grant the side opposite lastGrant.
  - on grant: latch addr, we (forced 0 for I), wdata (0 for I) into port registers; update lastGrant; clear waitCnt.
- I_BUSY/D_BUSY: memEn=1, memWe=latched we, memAddr/memWdata come from the latched registers; requester input changes are ignored.
  - memReady=1 → capture memRdata into the side's rdata register, err=0, go RESP.
  - memReady=0 and waitCnt==TIMEOUT-1 → rdata register=0, err=1, go RESP.
  - otherwise waitCnt+1. waitCnt is $clog2(TIMEOUT+1) bits and never wraps.
  - memReady and timeout in the same cycle: memReady wins, no error.
- RESP: memEn=0. Assert ack (and err if set) of the granted side only, for exactly one cycle. Requests are ignored in this cycle. Always go to IDLE.
- Requester contract: drop req at the edge where it samples ack=1. Re-asserting req the following cycle is legal and may be granted in that IDLE cycle.
- iRdata/dRdata/iErr/dErr hold their value until that side's next RESP.
- Store responses carry captured memRdata in dRdata; the core ignores it.

## Timing
- Reset (sync, RES=1 at edge): state=IDLE, lastGrant=D (first tie grants I), waitCnt=0. All outputs are 0: iAck, dAck, iErr, dErr, iRdata, dRdata, memEn, memWe, memAddr, memWdata.
- Reset mid-access: abort at that edge with no ack and no error. memEn=0 from the next cycle, and the requester must re-issue.
- Latency, with req high in IDLE at cycle 0:
  - memEn high from cycle 1.
  - memReady at cycle 1+W → ack at cycle 2+W.
  - Minimum is 2 cycles (W=0).
- Timeout: memEn is high for exactly TIMEOUT cycles, then error ack at cycle TIMEOUT+1.
- Back-to-back accesses to the same side: at least 3 cycles apart (BUSY, RESP, IDLE).
- memEn is never high in IDLE or RESP. memWe is never high without memEn. iAck and dAck are never high together.

## Test plan
- Fetch zero-wait: iReq=1, iAddr=0x100, memReady tied 1, memRdata=0x00500093 → memEn/memAddr=0x100 at cycle 1, iAck=1 with iRdata=0x00500093 and iErr=0 at cycle 2, memWe=0 throughout.
- Store with 3 wait states: dReq=1, dWe=1, dAddr=0x2000, dWdata=0xDEADBEEF, memReady high on the 4th busy cycle → memWe=1 for 4 cycles, dAck at cycle 5, no iAck.
- Tie round-robin: after reset, assert iReq and dReq together, each re-asserted after its ack → grant order I, D, I, D, and memAddr alternates between iAddr and dAddr.
- Timeout: TIMEOUT=15, dReq load to 0x3000, memReady held 0 → memEn high for 15 cycles, dAck=1 with dErr=1 and dRdata=0 at cycle 16. Then a fetch with memReady=1 completes with iErr=0.
- Ready on last wait cycle: memReady=1 exactly at waitCnt=TIMEOUT-1 with memRdata=0x1234 → ack with err=0 and rdata=0x1234.
- Reset mid-access: RES=1 for one edge during D_BUSY → memEn=0 and all outputs 0 the next cycle, no dAck. A re-issued dReq completes normally.
